// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core, host) for the single-port 256x8 data memory.
// Optional stall counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          Reset_n,
  // Handshake: a request is accepted in the cycle where req & gnt; the
  // requester holds req and its fields stable until then (no skid buffer here).
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state_dbg
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   core_stall_cnt,
  output logic [15:0]   host_stall_cnt
`endif
);

  generate
    if (MEM_RD_LAT != 1) begin : g_lat_check
      $error("dmem_arbiter supports MEM_RD_LAT == 1 only");
    end
  endgenerate

  typedef enum logic [1:0] {
    LAST_CORE  = 2'd0,
    LAST_HOST  = 2'd1,
    HOST_OWNED = 2'd2
  } arb_state_t;

  arb_state_t    state;
  logic          core_pend;
  logic          host_pend;
  logic [DW-1:0] core_rdata_q;
  logic [DW-1:0] host_rdata_q;
  logic          host_stall;

  // The last winner loses the next conflict; HOST_OWNED locks the core out.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    case (state)
      LAST_CORE: begin
        host_gnt = host_req;
        core_gnt = core_req & ~host_req;
      end
      LAST_HOST: begin
        core_gnt = core_req;
        host_gnt = host_req & ~core_req;
      end
      HOST_OWNED: begin
        host_gnt = host_req;
        core_gnt = 1'b0;
      end
      default: begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  assign mem_en     = core_gnt | host_gnt;
  assign core_stall = core_req & ~core_gnt;
  assign host_stall = host_req & ~host_gnt;
  assign state_dbg  = state;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state        <= LAST_CORE;
      core_pend    <= 1'b0;
      host_pend    <= 1'b0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (host_gnt && host_lock)
        state <= HOST_OWNED;
      else if (state == HOST_OWNED && !host_lock)
        state <= LAST_HOST;
      else if (host_gnt)
        state <= LAST_HOST;
      else if (core_gnt)
        state <= LAST_CORE;
      core_pend <= core_gnt & ~core_we;
      host_pend <= host_gnt & ~host_we;
      if (core_pend) core_rdata_q <= mem_rdata;
      if (host_pend) host_rdata_q <= mem_rdata;
    end
  end

  // Read data is passed straight through in the return cycle, then held.
  assign core_rvalid = core_pend;
  assign host_rvalid = host_pend;
  assign core_rdata  = core_pend ? mem_rdata : core_rdata_q;
  assign host_rdata  = host_pend ? mem_rdata : host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] core_stall_q;
  logic [15:0] host_stall_q;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      core_stall_q <= '0;
      host_stall_q <= '0;
    end else begin
      if (core_stall && core_stall_q != 16'hFFFF) core_stall_q <= core_stall_q + 16'd1;
      if (host_stall && host_stall_q != 16'hFFFF) host_stall_q <= host_stall_q + 16'd1;
    end
  end

  assign core_stall_cnt = core_stall_q;
  assign host_stall_cnt = host_stall_q;
`else
  logic unused_host_stall;
  assign unused_host_stall = host_stall;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: the processor core (load/store path) and a host/loader port used to preload program operands and dump results.
- Grants at most one access per cycle and stalls the loser.
- Provides a host lock so a multi-byte preload or dump burst cannot be interleaved with core accesses.
- Sits between TopLevel's load/store logic and data_mem1.

Parameters:
AW, 8, address width (256-byte data memory)
DW, 8, data width
MEM_RD_LAT, 1, data memory read latency in cycles; only 1 is supported

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset_n  in  1  synchronous, active-low reset
core_req  in  1  core requests a memory access this cycle
core_we  in  1  1 = write, 0 = read
core_addr  in  AW  core address
core_wdata  in  DW  core write data
core_gnt  out  1  core access accepted this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid
core_rdata  out  DW  core read data
host_req  in  1  host requests a memory access
host_we  in  1  1 = write, 0 = read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_lock  in  1  hold memory ownership for the host after its next grant
host_gnt  out  1  host access accepted this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DW  host read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_RD_LAT cycles after mem_en & ~mem_we

Behaviour:
- Arbiter state register with states LAST_CORE, LAST_HOST and HOST_OWNED. Reset state is LAST_CORE, so the host wins the first conflict.
- Grants are combinational from the requests and the registered state.
- mem_en = core_gnt | host_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted requester.
- When nothing is granted, all mem_* outputs are 0.
- Grant rules:
  - LAST_CORE: host_req wins if asserted, else core_req.
  - LAST_HOST: core_req wins if asserted, else host_req.
  - HOST_OWNED: only the host is granted; core_gnt = 0 even when the host is idle.
- State update each cycle:
  - On a host grant with host_lock = 1, next state is HOST_OWNED.
  - In HOST_OWNED, host_lock = 0 gives next state LAST_HOST, so the core wins the next conflict.
  - Otherwise, on any grant, the state records the winner. With no grant, the state holds.
- host_lock without a host grant has no effect.
- Lock asserted in a cycle where the core wins: ownership begins at the host's next grant.
- Read return:
  - A 1-deep owner tag pipeline, registered.
  - The granted read's tag produces {owner}_rvalid exactly 1 cycle after the grant, and {owner}_rdata = mem_rdata in that cycle.
  - The non-owner's rvalid is 0 and its rdata holds its last value.
  - Writes never produce rvalid.
- Back-to-back reads by alternating owners each return in order, one per cycle.
- Both requesters writing the same address in one cycle: only the granted write reaches memory; the loser retries under its stall.
- Requesters hold their request and its fields stable until granted. The arbiter does not latch losing requests.
- Reset values: state LAST_CORE; core_rvalid = host_rvalid = 0; core_rdata = host_rdata = 0.
- Reset asserted while a read is in flight: rvalid is suppressed the next cycle and any lock is dropped.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds output ports core_stall_cnt (16 bits) and host_stall_cnt (16 bits).
  - Each counts cycles with {owner}_req & ~{owner}_gnt.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- When undefined, these ports and counters do not exist; arbitration behaviour is identical either way.

Test Plan:
- Reset, then host writes 8'h5A to addr 8'h01 while the core is idle: host_gnt = 1 the same cycle, mem_we = 1, and no rvalid follows.
- Conflict: core read of 8'h00 and host read of 8'h1E in the same cycle from reset. Cycle 0 grants the host; cycle 1 grants the core. host_rvalid asserts at cycle 1 and core_rvalid at cycle 2, each with the matching memory data.
- Both requesting continuously for 6 cycles: grants alternate H,C,H,C,H,C and core_stall is high on the 3 host cycles.
- Host asserts host_lock with 30 consecutive writes while core_req is held high: 30 host grants with core_gnt = 0 throughout. Lock drops at cycle 30, and with both requesting at cycle 31 the core is granted.
- Reset_n pulled low in the cycle after a granted host read: host_rvalid = 0 the following cycle and state returns to LAST_CORE.
- With DMEM_ARB_STATS_EN defined, the 6-cycle contention case yields core_stall_cnt = 3 and host_stall_cnt = 3. Forcing the host stall count to 16'hFFFE, then 3 more stall cycles, reads 16'hFFFF.
